pipe_ctrl: RTL



---
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hold/rec controls for PC, IF_ID, ID_EX, EX_MEM, MEM_WB.
// Optional perf counters are built only when PIPE_PERF_EN is defined.
module pipe_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int LU_BUBBLES  = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             mem_busy_in,
    input  logic             if_wait_in,
    input  logic             id_lu_in,
    input  logic             ex_branch_in,
    output logic             pc_hold_out,
    output logic             pc_load_out,
    output logic             if_id_hold_out,
    output logic             if_id_rec_out,
    output logic             id_ex_hold_out,
    output logic             id_ex_rec_out,
    output logic             ex_mem_hold_out,
    output logic             ex_mem_rec_out,
    output logic             mem_wb_rec_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_hold_out     = 1'b0;
        pc_load_out     = 1'b0;
        if_id_hold_out  = 1'b0;
        if_id_rec_out   = 1'b1;
        id_ex_hold_out  = 1'b0;
        id_ex_rec_out   = 1'b1;
        ex_mem_hold_out = 1'b0;
        ex_mem_rec_out  = 1'b1;
        mem_wb_rec_out  = 1'b1;

        if (rst_in) begin
            if_id_rec_out  = 1'b0;
            id_ex_rec_out  = 1'b0;
            ex_mem_rec_out = 1'b0;
            mem_wb_rec_out = 1'b0;
            state_d        = ST_RUN;
            cnt_d          = 4'd0;
        end else if (mem_busy_in) begin
            // A held register is never simultaneously marked valid-new.
            pc_hold_out     = 1'b1;
            if_id_hold_out  = 1'b1;
            if_id_rec_out   = 1'b0;
            id_ex_hold_out  = 1'b1;
            id_ex_rec_out   = 1'b0;
            ex_mem_hold_out = 1'b1;
            ex_mem_rec_out  = 1'b0;
            mem_wb_rec_out  = 1'b0;
        end else if (ex_branch_in) begin
            pc_load_out   = 1'b1;
            if_id_rec_out = 1'b0;
            id_ex_rec_out = 1'b0;
            state_d       = (FLUSH_DEPTH == 0) ? ST_RUN : ST_FLUSH;
            cnt_d         = 4'(FLUSH_DEPTH);
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if_id_rec_out = 1'b0;
                    pc_hold_out   = if_wait_in;
                    cnt_d         = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end
                end
                ST_LU_STALL: begin
                    pc_hold_out    = 1'b1;
                    if_id_hold_out = 1'b1;
                    if_id_rec_out  = 1'b0;
                    id_ex_rec_out  = 1'b0;
                    cnt_d          = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    if (id_lu_in) begin
                        pc_hold_out    = 1'b1;
                        if_id_hold_out = 1'b1;
                        if_id_rec_out  = 1'b0;
                        id_ex_rec_out  = 1'b0;
                        if (LU_BUBBLES > 1) begin
                            state_d = ST_LU_STALL;
                            cnt_d   = 4'(LU_BUBBLES - 1);
                        end
                    end else if (if_wait_in) begin
                        pc_hold_out   = 1'b1;
                        if_id_rec_out = 1'b0;
                    end
                end
            endcase
        end
    end

    assign state_out = state_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold_out) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (pc_load_out) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;
    assign flush_cnt_out = flush_cnt_q;
`else
    assign stall_cnt_out = '0;
    assign flush_cnt_out = '0;
`endif

endmodule
